f_fetch_stage: RTL and testbench

//  F-stage of the 5-stage MIPS pipeline. Holds the fetch PC and issues requests to instruction memory.

---
 rtl/f_fetch_stage_if.sv | 21 ++
 rtl/f_fetch_stage.sv | 100 ++++++++++
 tb/tb_f_fetch_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/f_fetch_stage_if.sv
// Instruction-memory port of the F stage: address/request out, ready/data back.
interface f_fetch_stage_if;
    logic [31:0] i_inst_addr;
    logic        i_inst_req;
    logic        i_inst_ready;
    logic [31:0] i_inst_rdata;

    modport master (
        output i_inst_addr,
        output i_inst_req,
        input  i_inst_ready,
        input  i_inst_rdata
    );

    modport slave (
        input  i_inst_addr,
        input  i_inst_req,
        output i_inst_ready,
        output i_inst_rdata
    );
endinterface

// File: rtl/f_fetch_stage.sv
// MIPS F stage: fetch PC, multi-cycle instruction-memory handshake, F/D register,
// and a one-entry buffer that parks a returned word while the hazard unit stalls.
module f_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            npc,
    input  logic                   stall,
    input  logic                   flush_D,
    f_fetch_stage_if.master        imem,
    output logic                   f_busy,
    output logic [31:0]            pc_F,
    output logic [31:0]            pc_D,
    output logic [31:0]            instr_D,
    output logic                   valid_D,
    output logic                   exc_adel_D
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] BUF   = 1'b1;

    logic [0:0]  state;
    logic [31:0] buf_word;
    logic        buf_exc;

    logic        legal;
    logic        got;
    logic        fire;
    logic [31:0] word;
    logic        word_exc;
    logic        req;

    assign legal = (pc_F[1:0] == 2'b00) && (pc_F >= PC_LO) && (pc_F <= PC_HI);

    // Illegal PCs never reach memory; they complete at once as a nop tagged AdEL.
    always_comb begin
        req      = 1'b0;
        got      = 1'b1;
        word     = '0;
        word_exc = 1'b0;
        case (state)
            FETCH: begin
                req      = legal;
                got      = imem.i_inst_ready || !legal;
                word     = legal ? imem.i_inst_rdata : '0;
                word_exc = !legal;
            end
            default: begin
                req      = 1'b0;
                got      = 1'b1;
                word     = buf_word;
                word_exc = buf_exc;
            end
        endcase
    end

    assign imem.i_inst_addr = pc_F;
    assign imem.i_inst_req  = req;
    assign f_busy           = !got;
    assign fire             = got && !stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_F       <= PC_RESET;
            pc_D       <= '0;
            instr_D    <= '0;
            valid_D    <= 1'b0;
            exc_adel_D <= 1'b0;
            state      <= FETCH;
            buf_word   <= '0;
            buf_exc    <= 1'b0;
        end else begin
            if (fire) begin
                pc_F  <= npc;
                state <= FETCH;
            end else if (got && (state == FETCH)) begin
                buf_word <= word;
                buf_exc  <= word_exc;
                state    <= BUF;
            end

            // Flush wins over both stall and fire for the F/D register only.
            if (flush_D) begin
                pc_D       <= pc_F;
                instr_D    <= '0;
                valid_D    <= 1'b0;
                exc_adel_D <= 1'b0;
            end else if (fire) begin
                pc_D       <= pc_F;
                instr_D    <= word;
                valid_D    <= 1'b1;
                exc_adel_D <= word_exc;
            end
        end
    end

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: a reference model pushes expected F/D state per cycle
// into a queue, which is popped and compared just after each rising edge.
module tb_f_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        flush_D;
    logic        f_busy;
    logic [31:0] pc_F, pc_D, instr_D;
    logic        valid_D, exc_adel_D;

    f_fetch_stage_if imem ();

    f_fetch_stage #(
        .PC_RESET (32'h0000_3000),
        .PC_LO    (32'h0000_3000),
        .PC_HI    (32'h0000_6FFC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .flush_D    (flush_D),
        .imem       (imem.master),
        .f_busy     (f_busy),
        .pc_F       (pc_F),
        .pc_D       (pc_D),
        .instr_D    (instr_D),
        .valid_D    (valid_D),
        .exc_adel_D (exc_adel_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] pc_d;
        logic [31:0] instr;
        logic        valid;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_pc = 32'h0000_3000;
    logic        m_buf = 1'b0;
    logic [31:0] m_bw = '0;
    logic        m_be = 1'b0;
    logic [31:0] m_pcd = '0, m_ins = '0;
    logic        m_val = 1'b0, m_exc = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2400_0000 ^ {a[15:0], ~a[15:0]};
    endfunction

    // One clock: drive at negedge, check combinational outputs, predict, check after posedge.
    task automatic step(input logic rst_v, input logic [31:0] npc_v, input logic st,
                        input logic fl, input logic rdy, input logic [31:0] rd);
        logic        lg, got, req, exc, fire;
        logic [31:0] word;
        exp_t        e, o;
        @(negedge clk);
        reset = rst_v; npc = npc_v; stall = st; flush_D = fl;
        imem.i_inst_ready = rdy; imem.i_inst_rdata = rd;
        #1;
        lg = m_legal(m_pc);
        if (!m_buf) begin
            req = lg; got = rdy || !lg; word = lg ? rd : 32'h0; exc = !lg;
        end else begin
            req = 1'b0; got = 1'b1; word = m_bw; exc = m_be;
        end
        check_eq("addr", imem.i_inst_addr, m_pc);
        check_eq("req", {31'b0, imem.i_inst_req}, {31'b0, req});
        check_eq("busy", {31'b0, f_busy}, {31'b0, !got});

        if (!rst_v) begin
            m_pc = 32'h0000_3000; m_buf = 1'b0; m_bw = '0; m_be = 1'b0;
            m_pcd = '0; m_ins = '0; m_val = 1'b0; m_exc = 1'b0;
        end else begin
            fire = got && !st;
            if (fl) begin
                m_pcd = m_pc; m_ins = '0; m_val = 1'b0; m_exc = 1'b0;
            end else if (fire) begin
                m_pcd = m_pc; m_ins = word; m_val = 1'b1; m_exc = exc;
            end
            if (fire) begin
                m_pc = npc_v; m_buf = 1'b0;
            end else if (got && !m_buf) begin
                m_buf = 1'b1; m_bw = word; m_be = exc;
            end
        end
        e.pc_f = m_pc; e.pc_d = m_pcd; e.instr = m_ins; e.valid = m_val; e.exc = m_exc;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd0, 32'd1);
        end else begin
            o = exp_q.pop_front();
            check_eq("pc_F", pc_F, o.pc_f);
            check_eq("pc_D", pc_D, o.pc_d);
            check_eq("instr_D", instr_D, o.instr);
            check_eq("valid_D", {31'b0, valid_D}, {31'b0, o.valid});
            check_eq("exc_adel_D", {31'b0, exc_adel_D}, {31'b0, o.exc});
        end
    endtask

    // Normal advance: npc = pc_F + 4, memory answers with its word.
    task automatic go(input logic st, input logic fl, input logic rdy);
        step(1'b1, m_pc + 32'd4, st, fl, rdy, mem_word(m_pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; npc = '0; stall = 1'b0; flush_D = 1'b0;
        imem.i_inst_ready = 1'b0; imem.i_inst_rdata = '0;

        // reset for two cycles
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check_eq("rst_pc_F", pc_F, 32'h0000_3000);
        check_eq("rst_valid", {31'b0, valid_D}, 32'd0);
        check_eq("rst_instr", instr_D, 32'd0);

        // streaming, one per cycle
        go(1'b0, 1'b0, 1'b1);
        go(1'b0, 1'b0, 1'b1);
        check_eq("stream_pc_F", pc_F, 32'h0000_3008);
        check_eq("stream_instr", instr_D, mem_word(32'h0000_3004));

        // memory wait of 3 cycles, then fire
        repeat (3) go(1'b0, 1'b0, 1'b0);
        check_eq("wait_pc_F", pc_F, 32'h0000_3008);
        go(1'b0, 1'b0, 1'b1);

        // stall with ready: BUF, ready ignored afterwards
        go(1'b1, 1'b0, 1'b1);
        go(1'b1, 1'b0, 1'b1);
        step(1'b1, m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'hBAD0_BAD0);
        check_eq("buf_instr", instr_D, mem_word(32'h0000_300C));

        // misaligned PC -> AdEL nop
        step(1'b1, 32'h0000_3002, 1'b0, 1'b0, 1'b1, mem_word(m_pc));
        step(1'b1, 32'h0000_3020, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
        check_eq("adel_pc_D", pc_D, 32'h0000_3002);
        check_eq("adel_exc", {31'b0, exc_adel_D}, 32'd1);

        // range boundaries: 6FFC legal, 7000 and 2FFC illegal
        step(1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 1'b1, mem_word(m_pc));
        step(1'b1, 32'h0000_7000, 1'b0, 1'b0, 1'b1, mem_word(m_pc));
        step(1'b1, 32'h0000_2FFC, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h0000_3000, 1'b0, 1'b0, 1'b1, 32'h0);

        // flush with fire, flush with stall
        go(1'b0, 1'b1, 1'b1);
        go(1'b1, 1'b1, 1'b1);
        go(1'b0, 1'b0, 1'b0);
        go(1'b0, 1'b0, 1'b1);

        // reset while waiting, then while in BUF
        go(1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("rst_wait_pc_F", pc_F, 32'h0000_3000);
        go(1'b0, 1'b0, 1'b1);
        go(1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0000_4000, 1'b1, 1'b0, 1'b1, 32'h0);
        go(1'b0, 1'b0, 1'b0);
        go(1'b0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] nxt;
            int unsigned r;
            r = $urandom_range(0, 19);
            if (r < 14)       nxt = m_pc + 32'd4;
            else if (r == 14) nxt = 32'h0000_6FFC;
            else if (r == 15) nxt = 32'h0000_7000;
            else if (r == 16) nxt = 32'h0000_2FFC;
            else if (r == 17) nxt = 32'h0000_3000 + {18'b0, $urandom_range(0, 4095), 2'b00};
            else              nxt = $urandom;
            step(($urandom_range(0, 49) != 0), nxt,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
